ctr_mode_ctrl: RTL and testbench

CTR_MODE_CTRL -- requirements
Module: ctr_mode_ctrl

---
 rtl/ctr_mode_ctrl_if.sv | 27 ++
 rtl/ctr_mode_ctrl.sv | 145 ++++++++++++++
 tb/tb_ctr_mode_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctr_mode_ctrl_if.sv
// Stream and AES-core bundle for the CTR-mode controller.
// master = controller side, slave = environment (plaintext source, ciphertext sink, AES core).
interface ctr_mode_ctrl_if;
    // Valid/ready: a beat transfers on a rising edge where valid and ready are both high.
    // Once valid is raised the producer holds data stable until that edge.
    // aes_en / aes_done are single-cycle pulses with no backpressure.
    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [127:0] aes_pt;
    logic         aes_en;
    logic [127:0] aes_ct;
    logic         aes_done;

    modport master (
        input  din, din_valid, dout_ready, aes_ct, aes_done,
        output din_ready, dout, dout_valid, aes_pt, aes_en
    );

    modport slave (
        output din, din_valid, dout_ready, aes_ct, aes_done,
        input  din_ready, dout, dout_valid, aes_pt, aes_en
    );
endinterface

// File: rtl/ctr_mode_ctrl.sv
// CTR-mode sequencer: walks a counter block through an external AES core and XORs plaintext.
// Optional AES-response watchdog enabled by defining CTR_MODE_WATCHDOG_EN.
module ctr_mode_ctrl #(
    parameter int CTR_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [127:0]          iv,
    input  logic [15:0]           num_blocks,
    ctr_mode_ctrl_if.master       bus,
    output logic                  busy,
    output logic                  msg_done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENC      = 3'd1,
        S_WAIT_KS  = 3'd2,
        S_WAIT_DIN = 3'd3,
        S_OUT      = 3'd4
    } state_t;

    state_t         state;
    logic [127:0]   ctr_reg;
    logic [127:0]   ks_reg;
    logic [127:0]   dout_reg;
    logic [15:0]    remaining;
    logic           aes_en_q;
    logic           din_ready_q;
    logic           dout_valid_q;
    logic           busy_q;
    logic           msg_done_q;
    logic [127:0]   ctr_next;

`ifdef CTR_MODE_WATCHDOG_EN
    logic [7:0]     wd_cnt;
    logic           err_q;
`endif

    // Only the low CTR_W bits count; the nonce part above them is carried through untouched.
    assign ctr_next = {ctr_reg[127:CTR_W], ctr_reg[CTR_W-1:0] + {{(CTR_W-1){1'b0}}, 1'b1}};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            ctr_reg      <= '0;
            ks_reg       <= '0;
            dout_reg     <= '0;
            remaining    <= '0;
            aes_en_q     <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            msg_done_q   <= 1'b0;
`ifdef CTR_MODE_WATCHDOG_EN
            wd_cnt       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            aes_en_q   <= 1'b0;
            msg_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_blocks != 16'd0) begin
                            ctr_reg   <= iv;
                            remaining <= num_blocks;
                            aes_en_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            state     <= S_ENC;
                        end else begin
                            msg_done_q <= 1'b1;
                        end
                    end
                end
                S_ENC: begin
`ifdef CTR_MODE_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT_KS;
                end
                S_WAIT_KS: begin
                    if (bus.aes_done) begin
                        ks_reg      <= bus.aes_ct;
                        din_ready_q <= 1'b1;
                        state       <= S_WAIT_DIN;
                    end
`ifdef CTR_MODE_WATCHDOG_EN
                    // 255 cycles in WAIT_KS with no response: abandon the message silently.
                    else if (wd_cnt == 8'd254) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                S_WAIT_DIN: begin
                    if (bus.din_valid && din_ready_q) begin
                        dout_reg     <= bus.din ^ ks_reg;
                        din_ready_q  <= 1'b0;
                        dout_valid_q <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.dout_ready) begin
                        dout_valid_q <= 1'b0;
                        remaining    <= remaining - 16'd1;
                        ctr_reg      <= ctr_next;
                        if (remaining == 16'd1) begin
                            msg_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            aes_en_q <= 1'b1;
                            state    <= S_ENC;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.aes_pt     = ctr_reg;
    assign bus.aes_en     = aes_en_q;
    assign bus.din_ready  = din_ready_q;
    assign bus.dout       = dout_reg;
    assign bus.dout_valid = dout_valid_q;
    assign busy           = busy_q;
    assign msg_done       = msg_done_q;
    assign dbg_state      = state;

`ifdef CTR_MODE_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ctr_mode_ctrl.sv
// Self-checking bench for ctr_mode_ctrl: message-level reference model, AES core model,
// randomized stream drivers and directed corner cases.
module tb_ctr_mode_ctrl;
  localparam int CTR_W = 32;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         start;
  logic [127:0] iv;
  logic [15:0]  num_blocks;
  logic         busy, msg_done, err;
  logic [2:0]   dbg_state;

  ctr_mode_ctrl_if bus();

  ctr_mode_ctrl #(.CTR_W(CTR_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .iv         (iv),
    .num_blocks (num_blocks),
    .bus        (bus),
    .busy       (busy),
    .msg_done   (msg_done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  logic [127:0] aes_key = 128'hFF;
  int           aes_lat = 10;      // 0 selects a random latency per block
  bit           aes_hang = 1'b0;
  bit           din_fixed_en = 1'b1;
  logic [127:0] din_fixed_val = 128'h1;
  int           din_gap_max = 0;
  int           ready_mode = 0;    // 0 always ready, 1 random, 2 five-cycle stall per block

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] aes_f(input logic [127:0] pt);
    return pt ^ aes_key;
  endfunction

  // Counter block number idx of a message: low CTR_W bits advance modulo 2^CTR_W.
  function automatic logic [127:0] ctr_blk(input logic [127:0] base, input int idx);
    logic [127:0] mask;
    mask = (128'd1 << CTR_W) - 128'd1;
    return (base & ~mask) | ((base + 128'(idx)) & mask);
  endfunction

  // ---------------- AES core model ----------------
  logic [127:0] aes_cap;
  int           aes_wait;
  initial begin
    bus.aes_done = 1'b0;
    bus.aes_ct   = '0;
    forever begin
      @(negedge CLK);
      if (RST_N && bus.aes_en && !aes_hang) begin
        aes_cap  = bus.aes_pt;
        aes_wait = (aes_lat == 0) ? $urandom_range(1, 12) : aes_lat;
        repeat (aes_wait) @(posedge CLK);
        #1;
        bus.aes_ct   = aes_f(aes_cap);
        bus.aes_done = 1'b1;
        @(posedge CLK);
        #1;
        bus.aes_done = 1'b0;
      end
    end
  end

  // ---------------- plaintext driver ----------------
  bit din_hs;
  int din_gap = 0;
  initial begin
    bus.din_valid = 1'b0;
    bus.din       = '0;
    forever begin
      @(negedge CLK);
      din_hs = bus.din_valid && bus.din_ready;
      @(posedge CLK);
      #1;
      if (din_hs) begin
        bus.din_valid = 1'b0;
        din_gap = $urandom_range(0, din_gap_max);
      end
      if (!bus.din_valid) begin
        if (din_gap == 0) begin
          bus.din_valid = 1'b1;
          bus.din = din_fixed_en ? din_fixed_val : rand128();
        end else begin
          din_gap--;
        end
      end
    end
  end

  // ---------------- ciphertext sink ----------------
  int stall_cnt = 0;
  initial begin
    bus.dout_ready = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.dout_valid && bus.dout_ready) stall_cnt = 0;
      else if (bus.dout_valid) stall_cnt++;
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = ($urandom_range(0, 3) != 0);
        default: bus.dout_ready = (stall_cnt >= 5);
      endcase
    end
  end

  // ---------------- reference model + compare process ----------------
  logic [127:0] exp_q[$];
  logic [127:0] pt_log[16];
  logic [127:0] out_log[16];
  int           n_pt_log = 0, n_out_log = 0;
  int           done_cnt = 0;
  bit           m_active = 0, m_done_next = 0, m_en_pending = 0, m_err = 0, m_hold = 0;
  bit           was_active;
  logic [127:0] m_iv = '0, m_hold_val = '0, m_exp;
  int           m_n = 0, m_en_idx = 0, m_done_idx = 0, m_din_idx = 0, m_out_idx = 0, m_wait = 0;

  task automatic model_clear();
    m_active = 0; m_done_next = 0; m_en_pending = 0; m_hold = 0;
    m_en_idx = 0; m_done_idx = 0; m_din_idx = 0; m_out_idx = 0; m_wait = 0;
    exp_q.delete();
  endtask

  always @(negedge CLK) begin
    if (!RST_N) begin
      chk("rst_busy", busy, 0);
      chk("rst_msg_done", msg_done, 0);
      chk("rst_err", err, 0);
      chk("rst_aes_en", bus.aes_en, 0);
      chk("rst_din_ready", bus.din_ready, 0);
      chk("rst_dout_valid", bus.dout_valid, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_aes_pt", bus.aes_pt, 0);
      chk("rst_state", dbg_state, 0);
      model_clear();
      m_err = 0;
    end else begin
      was_active = m_active;
      chk("busy", busy, m_active);
      chk("msg_done", msg_done, m_done_next);
      chk("err", err, m_err);
      chk("aes_en", bus.aes_en, m_en_pending);
      chk("din_ready", bus.din_ready, m_done_idx > m_din_idx);
      chk("dout_valid", bus.dout_valid, m_din_idx > m_out_idx);
      if (m_hold) chk("dout_stable", bus.dout, m_hold_val);
      m_done_next = 0;
      m_en_pending = 0;

      if (msg_done) done_cnt++;
      if (bus.aes_en) begin
        chk("one_in_flight", m_en_idx - m_out_idx, 0);
        chk("aes_pt", bus.aes_pt, ctr_blk(m_iv, m_en_idx));
        if (n_pt_log < 16) begin pt_log[n_pt_log] = bus.aes_pt; n_pt_log++; end
        m_en_idx++;
        m_wait = 0;
      end
      if (bus.aes_done && m_done_idx < m_en_idx) m_done_idx++;
      if (bus.din_valid && bus.din_ready) begin
        exp_q.push_back(bus.din ^ aes_f(ctr_blk(m_iv, m_din_idx)));
        m_din_idx++;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        chk("dout_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          m_exp = exp_q.pop_front();
          chk("dout", bus.dout, m_exp);
        end
        if (n_out_log < 16) begin out_log[n_out_log] = bus.dout; n_out_log++; end
        m_out_idx++;
        m_hold = 0;
        if (m_out_idx == m_n) begin
          m_active = 0;
          m_done_next = 1;
        end else begin
          m_en_pending = 1;
        end
      end else begin
        m_hold = bus.dout_valid;
        m_hold_val = bus.dout;
      end
`ifdef CTR_MODE_WATCHDOG_EN
      if (!bus.aes_en && was_active && m_active && m_en_idx > m_done_idx) begin
        m_wait++;
        if (m_wait == 255) begin
          model_clear();
          m_err = 1;
        end
      end
`endif
      if (start && !was_active) begin
        if (num_blocks == 16'd0) begin
          m_done_next = 1;
        end else begin
          model_clear();
          m_active = 1;
          m_en_pending = 1;
          m_iv = iv;
          m_n = int'(num_blocks);
          n_pt_log = 0;
          n_out_log = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [127:0] v, input logic [15:0] n);
    @(posedge CLK);
    #1;
    start = 1'b1; iv = v; num_blocks = n;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_msgs(input int target, input int budget);
    int c;
    c = 0;
    while (done_cnt < target && c < budget) begin
      @(posedge CLK);
      c++;
    end
    chk("msg_done_count", done_cnt, target);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    repeat (cycles) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  int           tgt, nb;
  logic [127:0] r_iv;

  initial begin
    start = 1'b0; iv = '0; num_blocks = '0;
    #2 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // single block, literal result
    tgt = done_cnt + 1;
    do_start(128'h0, 16'd1);
    wait_msgs(tgt, 200);
    repeat (3) @(posedge CLK);
    chk("lit_pt0", pt_log[0], 128'h0);
    chk("lit_dout0", out_log[0], 128'hFE);
    chk("lit_one_done", done_cnt, tgt);

    // counter wrap keeps upper bits
    din_fixed_en = 1'b0;
    aes_lat = 0;
    tgt = done_cnt + 1;
    do_start({96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFF_FFFE}, 16'd3);
    wait_msgs(tgt, 300);
    chk("lit_wrap_pt0", pt_log[0], 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFE);
    chk("lit_wrap_pt1", pt_log[1], 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFF);
    chk("lit_wrap_pt2", pt_log[2], 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000000);

    // back-pressure and input gaps
    ready_mode = 2;
    din_gap_max = 4;
    aes_key = rand128();
    tgt = done_cnt + 1;
    do_start(rand128(), 16'd4);
    wait_msgs(tgt, 600);
    chk("stall_out_count", n_out_log, 4);
    ready_mode = 1;

    // empty message, then starts while busy
    tgt = done_cnt + 1;
    do_start(rand128(), 16'd0);
    wait_msgs(tgt, 10);
    tgt = done_cnt + 1;
    do_start(rand128(), 16'd3);
    repeat (2) @(posedge CLK);
    do_start(rand128(), 16'd0);
    do_start(rand128(), 16'd5);
    wait_msgs(tgt, 600);
    repeat (20) @(posedge CLK);
    chk("busy_start_ignored", done_cnt, tgt);
    chk("busy_start_blocks", n_out_log, 3);

    // reset while waiting for keystream, late aes_done afterwards
    aes_lat = 30;
    tgt = done_cnt;
    do_start(rand128(), 16'd2);
    repeat (8) @(posedge CLK);
    #1;
    chk("busy_before_rst", busy, 1);
    apply_reset(3);
    repeat (40) @(posedge CLK);
    chk("no_done_after_rst", done_cnt, tgt);

    // AES core never answers
    aes_hang = 1'b1;
    do_start(rand128(), 16'd1);
    repeat (300) @(posedge CLK);
    #1;
`ifdef CTR_MODE_WATCHDOG_EN
    chk("wd_err", err, 1);
    chk("wd_busy", busy, 0);
`else
    chk("nowd_err", err, 0);
    chk("nowd_busy", busy, 1);
`endif
    apply_reset(2);
    aes_hang = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("err_after_rst", err, 0);

    // randomized messages
    aes_lat = 0;
    din_gap_max = 3;
    for (int m = 0; m < 24; m++) begin
      r_iv = rand128();
      if ($urandom_range(0, 2) == 0) r_iv[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      nb = $urandom_range(0, 6);
      aes_key = rand128();
      ready_mode = $urandom_range(0, 2);
      tgt = done_cnt + 1;
      do_start(r_iv, 16'(nb));
      if (nb > 0 && $urandom_range(0, 1) == 1) begin
        repeat (2) @(posedge CLK);
        do_start(rand128(), 16'($urandom_range(0, 5)));
      end
      wait_msgs(tgt, 3000);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    repeat (5) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation time %0t exceeded", $time);
    $fatal(1, "bench time limit");
  end

endmodule
